io_bus_sequencer: RTL and testbench
===================================

IO_BUS_SEQUENCER -- requirements
Module: io_bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, the IO bus address width.
REQ-002 SHALL have parameter STROBE_CYCLES, default 2, the rd_n/wr_n low width in clocks; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; every state change occurs on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req[1:0], input, 2, per-requester request; index 0 is the CPU, index 1 is DMA.
REQ-006 SHALL have port we[1:0], input, 2, per-requester write (1) or read (0).
REQ-007 SHALL have port be0/be1, input, 2 each, per-requester byte enables; bit1 selects the high byte, bit0 the low byte.
REQ-008 SHALL have port addr0/addr1, input, ADDR_WIDTH each, per-requester address.
REQ-009 SHALL have port sel0/sel1, input, 1 each, per-requester select_dev.
REQ-010 SHALL have port wdata0/wdata1, input, 16 each, per-requester write data.
REQ-011 SHALL have port ack[1:0], output, 2, one-cycle completion pulse per requester.
REQ-012 SHALL have port err[1:0], output, 2, completion-with-error flag, valid with ack.
REQ-013 SHALL have port rdata, output, 16, read data, valid with ack; shared by both requesters.
REQ-014 SHALL have port bus_addr, output, ADDR_WIDTH; bus_sel, output, 1; and rd_n/wr_n/csh_n/csl_n, output, 1 each, all active-low, the IO bus controls.
REQ-015 SHALL have port bus_din, input, 16, sampled bus data; bus_dout, output, 16; and bus_oe, output, 1, external tristate enable.

Function
REQ-016 SHALL implement states IDLE, SETUP, STROBE, HOLD, ERR; all bus outputs SHALL be registered.
REQ-017 In IDLE, SHALL sample req; with no request pending, SHALL remain in IDLE.
REQ-018 SHALL arbitrate round-robin when both requests are set in IDLE: the requester not granted last wins; after reset, requester 0 has priority.
REQ-019 SHALL, on grant with nonzero be, latch the requester's we, be, addr, sel and wdata, then enter SETUP.
REQ-020 In SETUP (1 cycle), SHALL drive bus_addr, bus_sel, csh_n = ~be[1] and csl_n = ~be[0], and keep rd_n/wr_n high.
REQ-020 (cont.) For a write, bus_oe SHALL be 1 and bus_dout SHALL equal wdata from SETUP through HOLD inclusive.
REQ-021 In STROBE, SHALL hold rd_n (read) or wr_n (write) low for exactly STROBE_CYCLES cycles using a down-counter; the other strobe stays high.
REQ-022 On a read, SHALL capture bus_din into rdata on the last STROBE cycle; disabled bytes read as 8'h00.
REQ-023 In HOLD (1 cycle), SHALL raise both strobes while keeping addr, sel, cs and bus_oe stable.
REQ-023 (cont.) SHALL pulse ack[granted] = 1 for this cycle only, with err = 0; the next state is IDLE.
REQ-024 SHALL give a latency from the grant edge to ack of STROBE_CYCLES+2 cycles; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-025 In IDLE, csh_n/csl_n/rd_n/wr_n SHALL be 1, bus_oe SHALL be 0, and bus_addr/bus_sel/bus_dout SHALL hold their last values.
REQ-026 A grant with be = 2'b00 SHALL perform no bus cycle: the block enters ERR for 1 cycle, pulses ack and err for the granted requester, leaves rdata unchanged, and returns to IDLE.
REQ-027 rd_n and wr_n SHALL never be low simultaneously, and no strobe SHALL be low unless at least one cs_n is low.
REQ-028 Requesters SHALL hold their inputs stable from req until ack and SHALL drop req on the edge at which ack is seen; a req still high in IDLE is a new request.
REQ-029 A requester dropping req while its transaction is in flight SHALL NOT abort the cycle; the ack is still issued.

Reset
REQ-030 On reset, at the next edge, SHALL enter IDLE with rd_n = wr_n = csh_n = csl_n = 1, bus_oe = 0, ack = 0, err = 0, rdata = 0, bus_addr = 0, bus_sel = 0, bus_dout = 0, and round-robin priority set to requester 0.
REQ-031 Reset during SETUP/STROBE/HOLD/ERR SHALL abandon the transaction with no ack and with strobes high at the next edge.

Verification
REQ-032 Read: req0, we = 0, be = 11, addr = 0x1234, sel = 1, bus_din = 0xBEEF -> rd_n low for exactly 2 cycles, ack[0] 4 cycles after grant, rdata = 0xBEEF, wr_n always 1.
REQ-033 Byte write: req1, we = 1, be = 10, wdata = 0xA55A -> csh_n = 0, csl_n = 1, wr_n low 2 cycles, bus_oe = 1 for SETUP..HOLD, bus_dout = 0xA55A, ack[1].
REQ-034 Contention: req = 11 held continuously from reset -> grants alternate 0,1,0,1; no cycle overlap; at least one IDLE cycle between transactions.
REQ-035 Zero enable: req0 with be = 00 -> no strobe or cs activity; ack[0] = err[0] = 1 for one cycle; rdata unchanged.
REQ-036 Reset mid-STROBE of a write -> wr_n = 1 and bus_oe = 0 at the next edge, no ack; a subsequent req1 completes normally.
REQ-037 STROBE_CYCLES = 1 and 15 -> strobe low widths of exactly 1 and 15 cycles; latencies 3 and 17.

Source files
------------

// File: rtl/io_bus_sequencer_if.sv
// Requester-side handshake and IO-bus signals of the io_bus_sequencer.
// The sequencer uses the slave view; the requesters/bus model use the master view.
interface io_bus_sequencer_if #(
    parameter int ADDR_WIDTH = 15
);
    // requester side (index 0 = CPU, index 1 = DMA)
    logic [1:0]            req;
    logic [1:0]            we;
    logic [1:0]            be0;
    logic [1:0]            be1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  sel0;
    logic                  sel1;
    logic [15:0]           wdata0;
    logic [15:0]           wdata1;
    logic [1:0]            ack;
    logic [1:0]            err;
    logic [15:0]           rdata;

    // IO bus side
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_sel;
    logic                  rd_n;
    logic                  wr_n;
    logic                  csh_n;
    logic                  csl_n;
    logic [15:0]           bus_din;
    logic [15:0]           bus_dout;
    logic                  bus_oe;

    modport slave (
        input  req, we, be0, be1, addr0, addr1, sel0, sel1, wdata0, wdata1, bus_din,
        output ack, err, rdata, bus_addr, bus_sel, rd_n, wr_n, csh_n, csl_n, bus_dout, bus_oe
    );

    modport master (
        output req, we, be0, be1, addr0, addr1, sel0, sel1, wdata0, wdata1, bus_din,
        input  ack, err, rdata, bus_addr, bus_sel, rd_n, wr_n, csh_n, csl_n, bus_dout, bus_oe
    );
endinterface

// File: rtl/io_bus_sequencer.sv
// Two-requester IO bus sequencer: round-robin grant, SETUP/STROBE/HOLD bus cycle
// with registered active-low controls, and a one-cycle ERR path for empty byte enables.
module io_bus_sequencer #(
    parameter int ADDR_WIDTH    = 15,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    io_bus_sequencer_if.slave bus
);

    generate
        if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
            $error("io_bus_sequencer: STROBE_CYCLES must be within 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  last_gnt_reg;
    logic                  gnt_reg, gnt_next;
    logic                  we_reg, we_next;
    logic [1:0]            be_reg, be_next;

    logic                  grant;
    logic                  cand;
    logic                  cand_we;
    logic                  cand_sel;
    logic [1:0]            cand_be;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic [15:0]           cand_wdata;

    logic                  active_next;
    logic                  capture;
    logic [1:0]            ack_next;
    logic [1:0]            err_next;
    logic [15:0]           lane_data;

    logic                  rd_n_reg, wr_n_reg, csh_n_reg, csl_n_reg;
    logic                  bus_oe_reg, bus_sel_reg;
    logic [ADDR_WIDTH-1:0] bus_addr_reg;
    logic [15:0]           bus_dout_reg;
    logic [15:0]           rdata_reg;
    logic [1:0]            ack_reg, err_reg;

    // Round-robin candidate: on contention the requester not granted last wins.
    always_comb begin
        if (bus.req == 2'b11) begin
            cand = ~last_gnt_reg;
        end else begin
            cand = bus.req[1];
        end
        cand_we    = bus.we[cand];
        cand_be    = cand ? bus.be1    : bus.be0;
        cand_addr  = cand ? bus.addr1  : bus.addr0;
        cand_sel   = cand ? bus.sel1   : bus.sel0;
        cand_wdata = cand ? bus.wdata1 : bus.wdata0;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gnt_next   = gnt_reg;
        grant      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    grant    = 1'b1;
                    gnt_next = cand;
                    state_next = (cand_be == 2'b00) ? ERR : SETUP;
                end
            end
            SETUP: begin
                state_next = STROBE;
                cnt_next   = STROBE_LOAD;
            end
            STROBE: begin
                if (cnt_reg == 4'd0) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            HOLD:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        we_next     = grant ? cand_we : we_reg;
        be_next     = grant ? cand_be : be_reg;
        active_next = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
        capture     = (state_reg == STROBE) && (cnt_reg == 4'd0) && !we_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign ack_next[gi] = ((state_next == HOLD) || (state_next == ERR)) &&
                                  (gnt_next == 1'(gi));
            assign err_next[gi] = (state_next == ERR) && (gnt_next == 1'(gi));
            // disabled byte lanes read back as zero
            assign lane_data[gi*8 +: 8] = be_reg[gi] ? bus.bus_din[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            last_gnt_reg <= 1'b1;
            gnt_reg      <= 1'b0;
            we_reg       <= 1'b0;
            be_reg       <= 2'b00;
            rd_n_reg     <= 1'b1;
            wr_n_reg     <= 1'b1;
            csh_n_reg    <= 1'b1;
            csl_n_reg    <= 1'b1;
            bus_oe_reg   <= 1'b0;
            bus_sel_reg  <= 1'b0;
            bus_addr_reg <= '0;
            bus_dout_reg <= 16'h0000;
            rdata_reg    <= 16'h0000;
            ack_reg      <= 2'b00;
            err_reg      <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gnt_reg   <= gnt_next;
            we_reg    <= we_next;
            be_reg    <= be_next;
            if (grant) begin
                last_gnt_reg <= gnt_next;
            end
            // an empty-enable grant never touches the bus, so address/data hold
            if (grant && (state_next == SETUP)) begin
                bus_addr_reg <= cand_addr;
                bus_sel_reg  <= cand_sel;
                if (cand_we) begin
                    bus_dout_reg <= cand_wdata;
                end
            end
            csh_n_reg  <= !(active_next && be_next[1]);
            csl_n_reg  <= !(active_next && be_next[0]);
            bus_oe_reg <= active_next && we_next;
            rd_n_reg   <= !((state_next == STROBE) && !we_next);
            wr_n_reg   <= !((state_next == STROBE) && we_next);
            if (capture) begin
                rdata_reg <= lane_data;
            end
            ack_reg <= ack_next;
            err_reg <= err_next;
        end
    end

    assign bus.ack      = ack_reg;
    assign bus.err      = err_reg;
    assign bus.rdata    = rdata_reg;
    assign bus.bus_addr = bus_addr_reg;
    assign bus.bus_sel  = bus_sel_reg;
    assign bus.rd_n     = rd_n_reg;
    assign bus.wr_n     = wr_n_reg;
    assign bus.csh_n    = csh_n_reg;
    assign bus.csl_n    = csl_n_reg;
    assign bus.bus_dout = bus_dout_reg;
    assign bus.bus_oe   = bus_oe_reg;

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Bench for io_bus_sequencer: three instances (STROBE_CYCLES 2, 1, 15) share one
// stimulus set; only the selected one sees requests and its outputs are observed.
module tb_io_bus_sequencer;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    io_bus_sequencer_if #(.ADDR_WIDTH(AW)) if_a ();
    io_bus_sequencer_if #(.ADDR_WIDTH(AW)) if_b ();
    io_bus_sequencer_if #(.ADDR_WIDTH(AW)) if_c ();

    logic [1:0]    t_req, t_we, t_be0, t_be1;
    logic [AW-1:0] t_addr0, t_addr1;
    logic          t_sel0, t_sel1;
    logic [15:0]   t_wdata0, t_wdata1, t_din;
    int            sel_dut;

    assign if_a.req = (sel_dut == 0) ? t_req : 2'b00;
    assign if_b.req = (sel_dut == 1) ? t_req : 2'b00;
    assign if_c.req = (sel_dut == 2) ? t_req : 2'b00;
    assign if_a.we = t_we;      assign if_b.we = t_we;      assign if_c.we = t_we;
    assign if_a.be0 = t_be0;    assign if_b.be0 = t_be0;    assign if_c.be0 = t_be0;
    assign if_a.be1 = t_be1;    assign if_b.be1 = t_be1;    assign if_c.be1 = t_be1;
    assign if_a.addr0 = t_addr0; assign if_b.addr0 = t_addr0; assign if_c.addr0 = t_addr0;
    assign if_a.addr1 = t_addr1; assign if_b.addr1 = t_addr1; assign if_c.addr1 = t_addr1;
    assign if_a.sel0 = t_sel0;  assign if_b.sel0 = t_sel0;  assign if_c.sel0 = t_sel0;
    assign if_a.sel1 = t_sel1;  assign if_b.sel1 = t_sel1;  assign if_c.sel1 = t_sel1;
    assign if_a.wdata0 = t_wdata0; assign if_b.wdata0 = t_wdata0; assign if_c.wdata0 = t_wdata0;
    assign if_a.wdata1 = t_wdata1; assign if_b.wdata1 = t_wdata1; assign if_c.wdata1 = t_wdata1;
    assign if_a.bus_din = t_din; assign if_b.bus_din = t_din; assign if_c.bus_din = t_din;

    io_bus_sequencer #(.ADDR_WIDTH(AW), .STROBE_CYCLES(2))  dut_a (.clk(clk), .reset(reset), .bus(if_a));
    io_bus_sequencer #(.ADDR_WIDTH(AW), .STROBE_CYCLES(1))  dut_b (.clk(clk), .reset(reset), .bus(if_b));
    io_bus_sequencer #(.ADDR_WIDTH(AW), .STROBE_CYCLES(15)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    logic [1:0]    m_ack, m_err;
    logic [15:0]   m_rdata, m_dout;
    logic [AW-1:0] m_addr;
    logic          m_sel, m_rd_n, m_wr_n, m_csh_n, m_csl_n, m_oe;

    always_comb begin
        case (sel_dut)
            1: begin
                m_ack = if_b.ack; m_err = if_b.err; m_rdata = if_b.rdata; m_dout = if_b.bus_dout;
                m_addr = if_b.bus_addr; m_sel = if_b.bus_sel; m_rd_n = if_b.rd_n; m_wr_n = if_b.wr_n;
                m_csh_n = if_b.csh_n; m_csl_n = if_b.csl_n; m_oe = if_b.bus_oe;
            end
            2: begin
                m_ack = if_c.ack; m_err = if_c.err; m_rdata = if_c.rdata; m_dout = if_c.bus_dout;
                m_addr = if_c.bus_addr; m_sel = if_c.bus_sel; m_rd_n = if_c.rd_n; m_wr_n = if_c.wr_n;
                m_csh_n = if_c.csh_n; m_csl_n = if_c.csl_n; m_oe = if_c.bus_oe;
            end
            default: begin
                m_ack = if_a.ack; m_err = if_a.err; m_rdata = if_a.rdata; m_dout = if_a.bus_dout;
                m_addr = if_a.bus_addr; m_sel = if_a.bus_sel; m_rd_n = if_a.rd_n; m_wr_n = if_a.wr_n;
                m_csh_n = if_a.csh_n; m_csl_n = if_a.csl_n; m_oe = if_a.bus_oe;
            end
        endcase
    end

    // reference model state
    int            last_gnt_m;
    logic [15:0]   rdata_m, dout_m;
    logic [AW-1:0] addr_m;
    logic          sel_m;
    int            n_checks = 0;
    int            n_err = 0;
    int            txn_no = 0;

    function automatic int n_of(input int s);
        return (s == 1) ? 1 : (s == 2) ? 15 : 2;
    endfunction

    function automatic logic [15:0] masked(input logic [1:0] b, input logic [15:0] d);
        return {b[1] ? d[15:8] : 8'h00, b[0] ? d[7:0] : 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_gnt_m = 1;
        rdata_m = 16'h0;
        dout_m = 16'h0;
        addr_m = '0;
        sel_m = 1'b0;
    endtask

    task automatic do_reset();
        t_req = 2'b00;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_ack", m_ack, 0);
        chk("rst_err", m_err, 0);
        chk("rst_ctl", {m_rd_n, m_wr_n, m_csh_n, m_csl_n, m_oe}, 5'b11110);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_bus", {m_addr, m_sel, m_dout}, 0);
        reset = 1'b0;
        model_reset();
    endtask

    // One requester transaction; cycle 1 is the first cycle after the grant edge.
    task automatic do_txn(input int id, input logic w, input logic [1:0] b, input logic [AW-1:0] a,
                          input logic s, input logic [15:0] wd, input logic [15:0] din);
        int n, k, rd_lo, wr_lo, oe_c, cs_c, bad;
        bit got;
        logic [1:0] ack_seen, err_seen;
        logic [15:0] rd_seen, exp_rd;
        n = n_of(sel_dut);
        k = 0; rd_lo = 0; wr_lo = 0; oe_c = 0; cs_c = 0; bad = 0; got = 0;
        ack_seen = 2'b00; err_seen = 2'b00; rd_seen = 16'h0;
        if (id == 0) begin
            t_we[0] = w; t_be0 = b; t_addr0 = a; t_sel0 = s; t_wdata0 = wd;
        end else begin
            t_we[1] = w; t_be1 = b; t_addr1 = a; t_sel1 = s; t_wdata1 = wd;
        end
        t_din = din;
        t_req[id] = 1'b1;
        while (!got && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (!m_rd_n) rd_lo++;
            if (!m_wr_n) wr_lo++;
            if (m_oe) oe_c++;
            if (!m_rd_n && !m_wr_n) bad++;
            if ((!m_rd_n || !m_wr_n) && m_csh_n && m_csl_n) bad++;
            if (!m_csh_n || !m_csl_n) begin
                cs_c++;
                if (m_addr !== a || m_sel !== s || m_csh_n !== ~b[1] || m_csl_n !== ~b[0]) bad++;
            end
            if (m_oe && m_dout !== wd) bad++;
            if (m_ack !== 2'b00) begin
                got = 1; ack_seen = m_ack; err_seen = m_err; rd_seen = m_rdata;
            end
        end
        t_req[id] = 1'b0;
        exp_rd = (!w && b != 2'b00) ? masked(b, din) : rdata_m;
        chk("ack_seen", 32'(got), 1);
        chk("ack_vec", ack_seen, 2'b01 << id);
        chk("err_vec", err_seen, (b == 2'b00) ? (2'b01 << id) : 0);
        chk("latency", k, (b == 2'b00) ? 1 : n + 2);
        chk("rd_low", rd_lo, (!w && b != 2'b00) ? n : 0);
        chk("wr_low", wr_lo, (w && b != 2'b00) ? n : 0);
        chk("oe_cycles", oe_c, (w && b != 2'b00) ? n + 2 : 0);
        chk("cs_cycles", cs_c, (b != 2'b00) ? n + 2 : 0);
        chk("bus_rules", bad, 0);
        chk("rdata", rd_seen, exp_rd);
        last_gnt_m = id;
        rdata_m = exp_rd;
        if (b != 2'b00) begin
            addr_m = a; sel_m = s;
            if (w) dout_m = wd;
        end
        @(posedge clk); @(negedge clk);
        chk("idle_ctl", {m_ack, m_rd_n, m_wr_n, m_csh_n, m_csl_n, m_oe}, 7'b0011110);
        chk("idle_hold", {m_addr, m_sel, m_dout}, {addr_m, sel_m, dout_m});
        $display("txn %0d: N=%0d id=%0d we=%0d be=%b addr=%h lat=%0d ack=%b err=%b rdata=%h",
                 txn_no, n, id, w, b, a, k, ack_seen, err_seen, rd_seen);
        txn_no++;
    endtask

    initial begin
        int k, bad, exp_id, acks;
        bit got;
        logic [1:0] ack_seen, rb;
        logic [15:0] rd_seen;
        t_req = 2'b00; t_we = 2'b00; t_be0 = 2'b00; t_be1 = 2'b00;
        t_addr0 = '0; t_addr1 = '0; t_sel0 = 1'b0; t_sel1 = 1'b0;
        t_wdata0 = 16'h0; t_wdata1 = 16'h0; t_din = 16'h0;
        sel_dut = 0;
        model_reset();

        do_reset();
        do_txn(0, 1'b0, 2'b11, 15'h1234, 1'b1, 16'h0000, 16'hBEEF);
        do_txn(0, 1'b0, 2'b00, 15'h0555, 1'b0, 16'h0000, 16'h1357);
        do_txn(1, 1'b1, 2'b10, 15'h0042, 1'b0, 16'hA55A, 16'h0000);

        for (int i = 0; i < 20; i++) begin
            rb = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb, AW'($urandom),
                   1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end

        // both requesters held continuously from reset
        do_reset();
        t_we = 2'b00; t_be0 = 2'b11; t_be1 = 2'b01;
        t_addr0 = 15'h0111; t_addr1 = 15'h0222; t_sel0 = 1'b1; t_sel1 = 1'b0;
        t_din = 16'($urandom);
        t_req = 2'b11;
        exp_id = (last_gnt_m == 0) ? 1 : 0;
        for (int t = 0; t < 4; t++) begin
            k = 0; bad = 0; got = 0; ack_seen = 2'b00; rd_seen = 16'h0;
            while (!got && k < 40) begin
                @(posedge clk); @(negedge clk);
                k++;
                if ((!m_csh_n || !m_csl_n) && m_addr !== ((exp_id == 0) ? t_addr0 : t_addr1)) bad++;
                if (m_ack !== 2'b00) begin
                    got = 1; ack_seen = m_ack; rd_seen = m_rdata;
                end
            end
            rdata_m = masked((exp_id == 0) ? t_be0 : t_be1, t_din);
            chk("rr_grant", ack_seen, 2'b01 << exp_id);
            chk("rr_latency", k, n_of(sel_dut) + 2);
            chk("rr_addr", bad, 0);
            chk("rr_rdata", rd_seen, rdata_m);
            @(posedge clk); @(negedge clk);
            chk("rr_gap", {m_csh_n, m_csl_n, m_rd_n, m_wr_n, m_ack}, 6'b111100);
            if (t == 3) t_req = 2'b00;
            $display("txn %0d: contention ack=%b expected_id=%0d lat=%0d rdata=%h",
                     txn_no, ack_seen, exp_id, k, rd_seen);
            txn_no++;
            last_gnt_m = exp_id;
            exp_id = 1 - exp_id;
        end

        // reset in the middle of a write strobe
        do_reset();
        t_we[1] = 1'b1; t_be1 = 2'b10; t_addr1 = 15'h0ABC; t_sel1 = 1'b0; t_wdata1 = 16'hA55A;
        t_req[1] = 1'b1;
        k = 0;
        while (m_wr_n !== 1'b0 && k < 20) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        chk("mid_reach_strobe", m_wr_n, 0);
        t_req = 2'b00;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_wr_n", m_wr_n, 1);
        chk("mid_oe", m_oe, 0);
        chk("mid_ack", m_ack, 0);
        reset = 1'b0;
        model_reset();
        acks = 0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (m_ack !== 2'b00) acks++;
        end
        chk("mid_no_ack", acks, 0);
        $display("txn %0d: reset mid-strobe, acks after reset=%0d", txn_no, acks);
        txn_no++;
        do_txn(1, 1'b1, 2'b10, 15'h0ABC, 1'b0, 16'hA55A, 16'h0000);

        // strobe width extremes
        sel_dut = 1;
        do_reset();
        do_txn(0, 1'b0, 2'b01, 15'h0777, 1'b1, 16'h0000, 16'hC3D4);
        do_txn(1, 1'b1, 2'b11, 15'h0778, 1'b0, 16'h6B6B, 16'h0000);
        sel_dut = 2;
        do_reset();
        do_txn(1, 1'b0, 2'b10, 15'h7FFF, 1'b1, 16'h0000, 16'h9A8B);
        do_txn(0, 1'b1, 2'b01, 15'h0001, 1'b1, 16'h1F2E, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
